// File: rtl/io_bridge_pkg.sv
// Shared bus encodings, register map and 7-segment glyph table for the I/O bridge.
package io_bridge_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned SW_W   = 8;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned NIB_W  = 4;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      MREAD    = 2'b01,
      MWRITE   = 2'b10,
      CMD_RSVD = 2'b11
   } mem_cmd_e;

   localparam logic [ADDR_W-1:0] IO_LED    = 9'h100;
   localparam logic [ADDR_W-1:0] IO_HEX    = 9'h120;
   localparam logic [ADDR_W-1:0] IO_SW     = 9'h140;
   localparam logic [ADDR_W-1:0] IO_STATUS = 9'h160;
   localparam logic [ADDR_W-1:0] IO_CNT    = 9'h180;

   // Active-low segments {g,f,e,d,c,b,a}
   function automatic logic [SEG_W-1:0] seg7(input logic [NIB_W-1:0] nib);
      seg7 = 7'b1111111;
      case (nib)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0010000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         4'hF: seg7 = 7'b0001110;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

endpackage

// File: rtl/io_bridge_if.sv
// CPU memory-bus signals shared between the CPU side and the I/O bridge.
interface io_bridge_if;

   io_bridge_pkg::mem_cmd_e mem_cmd;
   logic [8:0]              mem_addr;
   logic [15:0]             din;
   logic [15:0]             dout;
   logic                    dout_en;

   modport master (
      output mem_cmd, mem_addr, din,
      input  dout, dout_en
   );

   modport slave (
      input  mem_cmd, mem_addr, din,
      output dout, dout_en
   );

endinterface

// File: rtl/io_bridge_sw_debounce.sv
// Two-flop synchronizer plus whole-word debounce for the slide switches.
module sw_debounce
   import io_bridge_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [SW_W-1:0] i_sw,
   output logic [SW_W-1:0] o_stable,
   output logic            o_changed_c
);

   localparam int unsigned CNT_W = 8;

   logic [SW_W-1:0]  r_sync1;
   logic [SW_W-1:0]  r_sync2;
   logic [SW_W-1:0]  r_sync_q;
   logic [SW_W-1:0]  r_stable;
   logic [CNT_W-1:0] r_db_cnt;

   logic             w_differs;
   logic             w_restart;
   logic [CNT_W-1:0] w_cnt_eff;
   logic             w_accept;

   // A fresh value on the synchronized word counts as the first cycle of a new run
   assign w_differs   = (r_sync2 != r_stable);
   assign w_restart   = (r_sync2 != r_sync_q);
   assign w_cnt_eff   = w_restart ? '0 : r_db_cnt;
   assign w_accept    = w_differs && (w_cnt_eff == CNT_W'(DB_CYCLES - 1));
   assign o_stable    = r_stable;
   assign o_changed_c = w_accept;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync_q <= '0;
         r_stable <= '0;
         r_db_cnt <= '0;
      end else begin
         r_sync1  <= i_sw;
         r_sync2  <= r_sync1;
         r_sync_q <= r_sync2;
         if (!w_differs) begin
            r_db_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= w_cnt_eff + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped LED/HEX/switch/counter peripheral living in the upper half of the bus address space.
module io_bridge
   import io_bridge_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   io_bridge_if.slave       bus,
   input  logic [SW_W-1:0]  sw,
   output logic [SW_W-1:0]  ledr,
   output logic [SEG_W-1:0] hex0,
   output logic [SEG_W-1:0] hex1,
   output logic [SEG_W-1:0] hex2,
   output logic [SEG_W-1:0] hex3
);

   logic [SW_W-1:0]   r_ledr;
   logic [DATA_W-1:0] r_hex;
   logic [DATA_W-1:0] r_cnt;
   logic              r_sw_chg;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_en;

   logic              w_rd;
   logic              w_wr;
   logic              w_rd_hit;
   logic [DATA_W-1:0] w_rd_data;
   logic [SW_W-1:0]   w_sw_stable;
   logic              w_sw_changed;

   sw_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_sw_debounce (
      .clk         (clk),
      .reset       (reset),
      .i_sw        (sw),
      .o_stable    (w_sw_stable),
      .o_changed_c (w_sw_changed)
   );

   assign w_rd = (bus.mem_cmd == MREAD)  && bus.mem_addr[ADDR_W-1];
   assign w_wr = (bus.mem_cmd == MWRITE) && bus.mem_addr[ADDR_W-1];

   // Read mux; unmapped addresses return zero and do not claim the bus
   always_comb begin
      w_rd_data = '0;
      w_rd_hit  = 1'b0;
      case (bus.mem_addr)
         IO_LED:    begin w_rd_data = {8'h00, r_ledr};      w_rd_hit = 1'b1; end
         IO_HEX:    begin w_rd_data = r_hex;                w_rd_hit = 1'b1; end
         IO_SW:     begin w_rd_data = {8'h00, w_sw_stable}; w_rd_hit = 1'b1; end
         IO_STATUS: begin w_rd_data = {15'b0, r_sw_chg};    w_rd_hit = 1'b1; end
         IO_CNT:    begin w_rd_data = r_cnt;                w_rd_hit = 1'b1; end
         default:   begin w_rd_data = '0;                   w_rd_hit = 1'b0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ledr    <= '0;
         r_hex     <= '0;
         r_cnt     <= '0;
         r_sw_chg  <= 1'b0;
         r_dout    <= '0;
         r_dout_en <= 1'b0;
      end else begin
         if (w_wr && (bus.mem_addr == IO_LED)) r_ledr <= bus.din[SW_W-1:0];
         if (w_wr && (bus.mem_addr == IO_HEX)) r_hex  <= bus.din;
         r_cnt <= (w_wr && (bus.mem_addr == IO_CNT)) ? bus.din : r_cnt + DATA_W'(1);
         // A new debounced value beats a simultaneous STATUS clear
         if (w_sw_changed) begin
            r_sw_chg <= 1'b1;
         end else if (w_rd && (bus.mem_addr == IO_STATUS)) begin
            r_sw_chg <= 1'b0;
         end
         if (w_rd) r_dout <= w_rd_data;
         r_dout_en <= w_rd && w_rd_hit;
      end
   end

   assign bus.dout    = r_dout;
   assign bus.dout_en = r_dout_en;
   assign ledr        = r_ledr;
   assign hex0        = seg7(r_hex[3:0]);
   assign hex1        = seg7(r_hex[7:4]);
   assign hex2        = seg7(r_hex[11:8]);
   assign hex3        = seg7(r_hex[15:12]);

endmodule
